// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - bundle layouts and FSM state type shared by the MEM stage
package mem_access_stage_pkg;

    // EX->MEM bundle (39 bits)
    localparam int EX_W          = 39;
    localparam int EX_ALU_LSB    = 23;
    localparam int EX_STORE_LSB  = 7;
    localparam int EX_WR_BIT     = 6;
    localparam int EX_RD_BIT     = 5;
    localparam int EX_WB_EN_BIT  = 4;
    localparam int EX_DEST_LSB   = 1;
    localparam int EX_MUX_BIT    = 0;

    // MEM->WB bundle (37 bits)
    localparam int WB_W          = 37;

    localparam int DATA_W        = 16;
    localparam int DEST_W        = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Packs the MEM->WB bundle: [36:21] alu, [20:5] read data, [4] wb_en, [3:1] dest, [0] mux.
    function automatic logic [WB_W-1:0] pack_wb(
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] rdata,
        input logic              wb_en,
        input logic [DEST_W-1:0] dest,
        input logic              mux
    );
        return {alu, rdata, wb_en, dest, mux};
    endfunction

endpackage

// File: rtl/mem_access_stage_fsm.sv
// rtl/mem_access_stage_fsm.sv - data-memory access sequencer: state, timeout counter, dmem request regs
//   clk, rst_n                       clock, async active-low reset
//   start, start_we                  begin an access this cycle (only honoured in IDLE), store select
//   start_addr, start_wdata          address / store data captured with start
//   dmem_ack                         completion pulse from memory, only looked at in ACCESS
//   state                            current FSM state
//   done                             access completes this cycle (ack or timeout)
//   timed_out                        completion forced by the timeout counter
//   dmem_req/we/addr/wdata           registered memory request bus
module dmem_access_fsm
    import mem_access_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_we,
    input  logic [DATA_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    input  logic              dmem_ack,
    output state_t            state,
    output logic              done,
    output logic              timed_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT < 1) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (count == CNT_LAST);

    always_comb begin
        state_next = state;
        done       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                done      = dmem_ack | timeout_hit;
                // An ack arriving on the last allowed cycle still counts as a real completion.
                timed_out = timeout_hit & ~dmem_ack;
                if (done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    count <= '0;
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= start_we;
                        dmem_addr  <= start_addr;
                        dmem_wdata <= start_wdata;
                    end
                end
                ST_ACCESS: begin
                    if (done) begin
                        count    <= '0;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    count    <= '0;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: load/store over req/ack bus, registered MEM->WB bundle
//   clk, rst_n          clock, async active-low reset
//   ex_valid            EX bundle valid (0 = bubble)
//   pipeline_reg_in     39-bit EX->MEM bundle
//   pipeline_reg_out    37-bit registered MEM->WB bundle
//   mem_stall           hold upstream stages this cycle
//   mem_op_dest         dest register of the instruction occupying MEM
//   mem_err             sticky error: access timeout or read+write both requested
//   dmem_req/we/addr/wdata, dmem_ack/rdata   data-memory bus
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [EX_W-1:0]   pipeline_reg_in,
    output logic [WB_W-1:0]   pipeline_reg_out,
    output logic              mem_stall,
    output logic [DEST_W-1:0] mem_op_dest,
    output logic              mem_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata
);

    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_store;
    logic              in_wr;
    logic              in_rd;
    logic              in_wb_en;
    logic [DEST_W-1:0] in_dest;
    logic              in_mux;

    assign in_alu   = pipeline_reg_in[EX_ALU_LSB +: DATA_W];
    assign in_store = pipeline_reg_in[EX_STORE_LSB +: DATA_W];
    assign in_wr    = pipeline_reg_in[EX_WR_BIT];
    assign in_rd    = pipeline_reg_in[EX_RD_BIT];
    assign in_wb_en = pipeline_reg_in[EX_WB_EN_BIT];
    assign in_dest  = pipeline_reg_in[EX_DEST_LSB +: DEST_W];
    assign in_mux   = pipeline_reg_in[EX_MUX_BIT];

    state_t state;
    logic   start;
    logic   done;
    logic   timed_out;

    // Captured instruction while the access is outstanding.
    logic [DATA_W-1:0] cap_alu;
    logic              cap_load;
    logic              cap_wb_en;
    logic [DEST_W-1:0] cap_dest;
    logic              cap_mux;

    logic [DATA_W-1:0] read_data;
    logic [WB_W-1:0]   out_next;

    assign start = (state == ST_IDLE) && ex_valid && (in_rd || in_wr);

    dmem_access_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_we    (in_wr),
        .start_addr  (in_alu),
        .start_wdata (in_store),
        .dmem_ack    (dmem_ack),
        .state       (state),
        .done        (done),
        .timed_out   (timed_out),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata)
    );

    // Only a pure load returns memory data; stores (including read+write) and timeouts give zero.
    assign read_data = (cap_load && dmem_ack) ? dmem_rdata : '0;

    always_comb begin
        out_next    = '0;
        mem_stall   = 1'b0;
        mem_op_dest = '0;
        if (state == ST_IDLE) begin
            mem_stall = start;
            if (ex_valid) begin
                mem_op_dest = in_dest;
                if (!(in_rd || in_wr)) begin
                    out_next = pack_wb(in_alu, '0, in_wb_en, in_dest, in_mux);
                end
            end
        end else begin
            mem_stall   = ~done;
            mem_op_dest = cap_dest;
            if (done) begin
                out_next = pack_wb(cap_alu, read_data, cap_wb_en, cap_dest, cap_mux);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipeline_reg_out <= '0;
            mem_err          <= 1'b0;
            cap_alu          <= '0;
            cap_load         <= 1'b0;
            cap_wb_en        <= 1'b0;
            cap_dest         <= '0;
            cap_mux          <= 1'b0;
        end else begin
            pipeline_reg_out <= out_next;
            if (start) begin
                cap_alu   <= in_alu;
                cap_load  <= in_rd & ~in_wr;
                cap_wb_en <= in_wb_en;
                cap_dest  <= in_dest;
                cap_mux   <= in_mux;
            end
            if ((start && in_rd && in_wr) || timed_out) begin
                mem_err <= 1'b1;
            end
        end
    end

endmodule
